temp_f_bcd_converter: RTL and testbench
=======================================

# temp_f_bcd_converter

- Converts one raw temperature-sensor sample (12-bit two's complement, 1/16 °C per LSB) to whole degrees Fahrenheit, packed as 3-digit BCD.
- Sits directly upstream of the display controller and drives its `TEMP_F` bus.
- Datapath is sequential: one scale step, bit-serial restoring division by 80, then double-dabble.
- Fixed latency, valid/ready input handshake, and a registered output that holds until the next conversion completes.

## Interface
Parameters:
- `RAW_W`, 12: raw sample width, two's complement.
- `DIV_STEPS`, 15: restoring-division iterations, equal to the numerator magnitude width.

Ports (one clock, `CLOCK_50`; reset is synchronous and active-high):
- `CLOCK_50`  in  1  system clock; all state changes on its rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `SAMPLE_C`  in  12  raw sensor value, 1/16 °C per LSB, signed.
- `SAMPLE_VALID`  in  1  `SAMPLE_C` is valid.
- `SAMPLE_READY`  out  1  block is idle and can accept a sample.
- `TEMP_F`  out  10  result as `{hundreds[1:0], tens[3:0], ones[3:0]}` BCD.
- `TEMP_VALID`  out  1  one-cycle pulse when `TEMP_F` updates.
- `CLAMPED`  out  1  last result was forced to 0 because the computed value was below 0 °F.

## Operation
- Conversion:
  - F = floor((raw·9 + 2560) / 80), where 2560 = 32·80.
  - The numerator is computed as signed 17-bit.
  - If the numerator is < 0: numerator forced to 0 and the clamp flag is set. Conversion still runs the full sequence, so latency is constant.
  - The non-negative numerator is ≤ 20983 and fits in 15 bits. The quotient is ≤ 262, 9 bits.
- FSM states: IDLE → LOAD → DIV → BCD → IDLE.
  - IDLE: `SAMPLE_READY`=1. On `SAMPLE_VALID`&&`SAMPLE_READY`, latch `SAMPLE_C` and go to LOAD.
  - LOAD (1 cycle): compute raw·9 + 2560 using shift-add (raw<<3 + raw). Apply the clamp. Clear the remainder and iteration counter. Go to DIV.
  - DIV: one restoring-division step per cycle. Shift the next numerator bit into the remainder; subtract 80 when remainder ≥ 80 and shift in the quotient bit. After `DIV_STEPS` steps, go to BCD.
  - BCD: 9-cycle double-dabble on the 9-bit quotient. Each cycle, add 3 to any BCD digit ≥ 5, then shift left. On the final step, register `TEMP_F` and `CLAMPED`, pulse `TEMP_VALID`, and go to IDLE.
- `SAMPLE_READY` = (state == IDLE). Samples offered while busy are not accepted; upstream holds `SAMPLE_VALID` and data until accepted.
- `TEMP_F` and `CLAMPED` change only on completion. Between conversions they hold their last value.
- Results above 399 cannot occur for a 12-bit input. The hundreds digit is still truncated to 2 bits, and no saturation logic is required.

## Timing
- Reset values:
  - state = IDLE, `SAMPLE_READY`=1 on the first cycle after reset.
  - `TEMP_F`=10'h000, `TEMP_VALID`=0, `CLAMPED`=0.
  - Counters and datapath registers = 0.
- Latency:
  - Sample accepted on edge k.
  - `TEMP_F` and `CLAMPED` update, and `TEMP_VALID`=1, after edge k+25. The pulse lasts exactly one cycle.
  - `SAMPLE_READY` is high again after edge k+25, so back-to-back throughput is one sample per 26 cycles.
- Completion cycle: a new `SAMPLE_VALID` in the same cycle that `TEMP_VALID` is high is accepted on the next edge. The result already registered is unaffected.
- Reset mid-operation: the conversion is aborted, all outputs return to reset values, and no `TEMP_VALID` is produced for the aborted sample.
- `RESET` and `SAMPLE_VALID` asserted together: reset wins and the sample is not accepted.

## Structure
- Shared package `greenhouse_pkg` holds:
  - the FSM state encoding;
  - `F_OFFSET_SCALED`=2560 and `F_DIVISOR`=80;
  - `RAW_W` and the `TEMP_F` field widths/positions, shared with the display controller.
- Natural sub-module: `bin9_to_bcd`, a sequential double-dabble.
  - Ports: start, 9-bit bin, done pulse, 10-bit BCD, plus `CLOCK_50`/`RESET`.
  - The parent FSM waits on its done signal instead of counting cycles itself.

## Test plan
- Reset, then idle: `TEMP_F`=10'h000, `TEMP_VALID`=0, `SAMPLE_READY`=1, `CLAMPED`=0.
- Normal values:
  - `SAMPLE_C`=12'h190 (25.0 °C) → after 25 edges `TEMP_F`=10'h077, one-cycle `TEMP_VALID`, `CLAMPED`=0.
  - 12'h640 → 10'h212.
  - 12'h7FF → 10'h262.
- Negative values:
  - 12'hFF0 (−1 °C) → 10'h030, `CLAMPED`=0.
  - 12'hE70 (−25 °C) → 10'h000, `CLAMPED`=1.
- Handshake: hold `SAMPLE_VALID` high continuously with a new value each acceptance. Check:
  - acceptances exactly 26 cycles apart;
  - `SAMPLE_READY` low throughout each conversion;
  - `TEMP_F` stable between `TEMP_VALID` pulses.
- Busy input: change `SAMPLE_C` while busy. The result reflects only the value latched at acceptance.
- Reset mid-operation: assert `RESET` at cycle k+10. There is no `TEMP_VALID` pulse, outputs go to reset values, and the next sample converts correctly.

Source files
------------

// File: rtl/greenhouse_pkg.sv
// Shared definitions for the greenhouse temperature path (converter + display controller).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package greenhouse_pkg;

    // Converter FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DIV  = 2'd2,
        ST_BCD  = 2'd3
    } state_t;

    // F = floor((raw*9 + 32*80) / 80) with raw in 1/16 degC
    localparam int F_OFFSET_SCALED = 2560;
    localparam int F_DIVISOR       = 80;

    // Raw sensor sample width (two's complement)
    localparam int RAW_W = 12;

    // Quotient width: largest Fahrenheit result (262) fits in 9 bits
    localparam int QUO_W = 9;

    // TEMP_F bus layout: {hundreds[1:0], tens[3:0], ones[3:0]}
    localparam int TEMP_F_W     = 10;
    localparam int BCD_ONES_LSB = 0;
    localparam int BCD_TENS_LSB = 4;
    localparam int BCD_HUND_LSB = 8;
    localparam int BCD_DIGIT_W  = 4;
    localparam int BCD_HUND_W   = 2;

endpackage

// File: rtl/temp_f_bcd_converter_bin9_to_bcd.sv
// Sequential double-dabble: 9-bit binary to {hundreds[1:0], tens, ones} BCD.
// Latency: 9 cycles; the start cycle performs the first step, o_done marks the 9th step.
// Backpressure: none; o_done/o_bcd are valid only in the final-step cycle and the parent must sample then.
module bin9_to_bcd
    import greenhouse_pkg::*;
(
    input  logic                CLOCK_50,
    input  logic                RESET,
    input  logic                i_start,
    input  logic [QUO_W-1:0]    i_bin,
    output logic                o_done,
    output logic [TEMP_F_W-1:0] o_bcd
);
    // Shift register layout: {bcd[TEMP_F_W-1:0], bin[QUO_W-1:0]}
    localparam int SH_W = TEMP_F_W + QUO_W;

    logic [SH_W-1:0] r_sh;
    logic [3:0]      r_cnt;
    logic            r_busy;

    logic [SH_W-1:0] w_src;
    logic [SH_W-1:0] w_adj;
    logic [SH_W-1:0] w_step;
    logic            w_unused_top;

    // One double-dabble step: adjust ones/tens digits >= 5 by +3, then shift left.
    // Hundreds never reaches 5 for results <= 399, so it is not adjusted.
    always_comb begin
        w_src = i_start ? {{TEMP_F_W{1'b0}}, i_bin} : r_sh;
        w_adj = w_src;
        for (int d = 0; d < 2; d++) begin
            if (w_src[QUO_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] >= 4'd5) begin
                w_adj[QUO_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] =
                    w_src[QUO_W + BCD_DIGIT_W*d +: BCD_DIGIT_W] + 4'd3;
            end
        end
        w_step = {w_adj[SH_W-2:0], 1'b0};
    end

    // The hundreds MSB shifted out is discarded: results stay below 400.
    assign w_unused_top = w_adj[SH_W-1];

    assign o_done = r_busy && (r_cnt == 4'd8);
    assign o_bcd  = w_step[SH_W-1:QUO_W];

    // Step counter and shift register; start performs step 1, eight more follow.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start || r_busy) begin
            r_sh <= w_step;
            if (o_done) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_busy <= 1'b1;
                r_cnt  <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/temp_f_bcd_converter.sv
// Raw 1/16 degC sample -> whole degF as 3-digit BCD (scale, restoring divide by 80, double-dabble).
// Latency: fixed 25 cycles from acceptance to TEMP_VALID; one sample per 26 cycles.
// Backpressure: SAMPLE_READY only in IDLE; upstream holds SAMPLE_VALID/SAMPLE_C until accepted.
module temp_f_bcd_converter #(
    parameter int RAW_W     = 12,
    parameter int DIV_STEPS = 15
) (
    input  logic             CLOCK_50,
    input  logic             RESET,
    input  logic [RAW_W-1:0] SAMPLE_C,
    input  logic             SAMPLE_VALID,
    output logic             SAMPLE_READY,
    output logic [9:0]       TEMP_F,
    output logic             TEMP_VALID,
    output logic             CLAMPED
);
    import greenhouse_pkg::state_t;
    import greenhouse_pkg::ST_IDLE;
    import greenhouse_pkg::ST_LOAD;
    import greenhouse_pkg::ST_DIV;
    import greenhouse_pkg::ST_BCD;
    import greenhouse_pkg::F_OFFSET_SCALED;
    import greenhouse_pkg::F_DIVISOR;
    import greenhouse_pkg::QUO_W;
    import greenhouse_pkg::TEMP_F_W;

    // raw*9 needs RAW_W+4 signed bits; adding the offset needs one more
    localparam int NUM_W = RAW_W + 5;
    localparam int CNT_W = $clog2(DIV_STEPS);
    localparam int REM_W = $clog2(F_DIVISOR);

    state_t                  r_state;
    logic signed [RAW_W-1:0] r_raw;
    logic [DIV_STEPS-1:0]    r_nq;        // numerator shifts out, quotient shifts in
    logic [REM_W-1:0]        r_rem;
    logic [CNT_W-1:0]        r_step;
    logic                    r_clamp_pend;
    logic                    r_bcd_start;

    logic signed [NUM_W-1:0] w_raw_ext;
    logic signed [NUM_W-1:0] w_num;
    logic [NUM_W-2-DIV_STEPS:0] w_unused_num_hi;
    logic [REM_W:0]          w_trial;
    logic                    w_ge;
    logic [REM_W:0]          w_rem_full;
    logic                    w_unused_rem_msb;
    logic                    w_bcd_done;
    logic [TEMP_F_W-1:0]     w_bcd;

    // Scale step: raw*9 as (raw<<3)+raw, then add 32*80
    assign w_raw_ext = NUM_W'(r_raw);
    assign w_num     = (w_raw_ext <<< 3) + w_raw_ext + NUM_W'(F_OFFSET_SCALED);

    // Non-negative numerator is <= 20983, so the bits above DIV_STEPS are always zero
    assign w_unused_num_hi = w_num[NUM_W-2:DIV_STEPS];

    // Restoring division step: bring in next numerator bit, subtract divisor if it fits
    assign w_trial    = {r_rem, r_nq[DIV_STEPS-1]};
    assign w_ge       = (w_trial >= (REM_W+1)'(F_DIVISOR));
    assign w_rem_full = w_ge ? (w_trial - (REM_W+1)'(F_DIVISOR)) : w_trial;
    assign w_unused_rem_msb = w_rem_full[REM_W];

    assign SAMPLE_READY = (r_state == ST_IDLE);

    bin9_to_bcd u_bcd (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .i_start  (r_bcd_start),
        .i_bin    (r_nq[QUO_W-1:0]),
        .o_done   (w_bcd_done),
        .o_bcd    (w_bcd)
    );

    // Conversion FSM with registered result outputs
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_state      <= ST_IDLE;
            r_raw        <= '0;
            r_nq         <= '0;
            r_rem        <= '0;
            r_step       <= '0;
            r_clamp_pend <= 1'b0;
            r_bcd_start  <= 1'b0;
            TEMP_F       <= '0;
            TEMP_VALID   <= 1'b0;
            CLAMPED      <= 1'b0;
        end else begin
            r_bcd_start <= 1'b0;
            TEMP_VALID  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (SAMPLE_VALID) begin
                        r_raw   <= SAMPLE_C;
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    // Below 0 degF: divide zero instead, so latency stays constant
                    if (w_num[NUM_W-1]) begin
                        r_nq         <= '0;
                        r_clamp_pend <= 1'b1;
                    end else begin
                        r_nq         <= w_num[DIV_STEPS-1:0];
                        r_clamp_pend <= 1'b0;
                    end
                    r_rem   <= '0;
                    r_step  <= '0;
                    r_state <= ST_DIV;
                end
                ST_DIV: begin
                    r_rem  <= w_rem_full[REM_W-1:0];
                    r_nq   <= {r_nq[DIV_STEPS-2:0], w_ge};
                    r_step <= r_step + CNT_W'(1);
                    if (r_step == CNT_W'(DIV_STEPS-1)) begin
                        r_bcd_start <= 1'b1;
                        r_state     <= ST_BCD;
                    end
                end
                ST_BCD: begin
                    if (w_bcd_done) begin
                        TEMP_F     <= w_bcd;
                        CLAMPED    <= r_clamp_pend;
                        TEMP_VALID <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_temp_f_bcd_converter.sv
// Scoreboard bench: acceptances push arithmetic-model results, monitor pops on TEMP_VALID.
// Latency: expects 25 edges from acceptance to TEMP_VALID.
// Backpressure: driver holds SAMPLE_VALID/SAMPLE_C until SAMPLE_READY.
module tb_temp_f_bcd_converter;

    logic        CLOCK_50;
    logic        RESET;
    logic [11:0] SAMPLE_C;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic [9:0]  TEMP_F;
    logic        TEMP_VALID;
    logic        CLAMPED;

    typedef struct {
        logic [9:0] tf;
        logic       cl;
        int         acc_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   last_rst = 1'b1;
    int   busy_until = 0;
    int   last_acc = -1;
    bit   held_break = 1'b1;
    bit   prev_tv = 1'b0;
    logic [9:0] last_tf = '0;
    logic       last_cl = 1'b0;

    temp_f_bcd_converter #(.RAW_W(12), .DIV_STEPS(15)) dut (
        .CLOCK_50     (CLOCK_50),
        .RESET        (RESET),
        .SAMPLE_C     (SAMPLE_C),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .TEMP_F       (TEMP_F),
        .TEMP_VALID   (TEMP_VALID),
        .CLAMPED      (CLAMPED)
    );

    initial begin
        CLOCK_50 = 1'b0;
        forever #5 CLOCK_50 = ~CLOCK_50;
    end

    // Reference: plain integer arithmetic, decimal digits packed as BCD
    function automatic exp_t model(input logic [11:0] raw, input int acc);
        exp_t e;
        int   r, num, f;
        r   = $signed(raw);
        num = r * 9 + 32 * 80;
        if (num < 0) begin
            f    = 0;
            e.cl = 1'b1;
        end else begin
            f    = num / 80;
            e.cl = 1'b0;
        end
        e.tf      = 10'(((f / 100) % 4) * 256 + ((f / 10) % 10) * 16 + (f % 10));
        e.acc_cyc = acc;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 'h%0h, expected 'h%0h", name, cyc, act, exp);
        end
    endtask

    always @(posedge CLOCK_50) begin
        cyc++;
        last_rst = RESET;
    end

    // Monitor and acceptance tracker, sampled mid-cycle
    always @(negedge CLOCK_50) begin
        if (last_rst) begin
            check("rst_temp_f", int'(TEMP_F), 0);
            check("rst_temp_valid", int'(TEMP_VALID), 0);
            check("rst_clamped", int'(CLAMPED), 0);
            check("rst_ready", int'(SAMPLE_READY), 1);
            exp_q.delete();
            busy_until = 0;
            last_tf    = '0;
            last_cl    = 1'b0;
            prev_tv    = 1'b0;
            held_break = 1'b1;
        end else begin
            if (TEMP_VALID) begin
                check("pulse_width", int'(prev_tv), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("temp_f", int'(TEMP_F), int'(e.tf));
                    check("clamped", int'(CLAMPED), int'(e.cl));
                    check("latency", cyc - e.acc_cyc, 25);
                end
                last_tf = TEMP_F;
                last_cl = CLAMPED;
            end else begin
                check("temp_f_hold", int'(TEMP_F), int'(last_tf));
                check("clamped_hold", int'(CLAMPED), int'(last_cl));
                if (exp_q.size() > 0 && cyc > exp_q[0].acc_cyc + 25) begin
                    check("result_timeout", cyc - exp_q[0].acc_cyc, 25);
                    void'(exp_q.pop_front());
                end
            end
            prev_tv = TEMP_VALID;
            check("ready", int'(SAMPLE_READY), (cyc >= busy_until) ? 1 : 0);
        end
        if (!SAMPLE_VALID) held_break = 1'b1;
        if (SAMPLE_VALID && !RESET && (cyc >= busy_until)) begin
            if (!held_break && last_acc >= 0)
                check("accept_spacing", (cyc + 1) - last_acc, 26);
            exp_q.push_back(model(SAMPLE_C, cyc + 1));
            busy_until = cyc + 26;
            last_acc   = cyc + 1;
            held_break = 1'b0;
        end
    end

    // Offer one sample and hold it until accepted
    task automatic send(input logic [11:0] v, input bit keep_valid);
        SAMPLE_C     = v;
        SAMPLE_VALID = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            if (SAMPLE_READY && !RESET) break;
        end
        @(posedge CLOCK_50);
        #1;
        if (!keep_valid) SAMPLE_VALID = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        logic [11:0] dir [7];
        dir[0] = 12'h190; dir[1] = 12'h640; dir[2] = 12'h7FF; dir[3] = 12'hFF0;
        dir[4] = 12'hE70; dir[5] = 12'h800; dir[6] = 12'h000;

        RESET        = 1'b1;
        SAMPLE_VALID = 1'b0;
        SAMPLE_C     = '0;
        idle(3);
        RESET = 1'b0;
        idle(2);

        // Directed values
        for (int i = 0; i < 7; i++) begin
            send(dir[i], 1'b0);
            idle(30);
        end

        // Back-to-back with SAMPLE_VALID held high
        for (int i = 0; i < 6; i++) send(12'($urandom), 1'b1);
        SAMPLE_VALID = 1'b0;
        idle(30);

        // Input scrambled while busy
        for (int i = 0; i < 3; i++) begin
            send(12'($urandom), 1'b0);
            for (int j = 0; j < 22; j++) begin
                SAMPLE_C = 12'($urandom);
                idle(1);
            end
            idle(5);
        end

        // Reset mid-conversion: RESET sampled on edge k+10
        send(12'h190, 1'b0);
        idle(9);
        RESET = 1'b0;
        RESET = 1'b1;
        idle(1);
        RESET = 1'b0;
        idle(3);
        send(12'h640, 1'b0);
        idle(30);

        // Reset and valid together: reset wins
        RESET        = 1'b1;
        SAMPLE_VALID = 1'b1;
        SAMPLE_C     = 12'h7FF;
        idle(2);
        RESET        = 1'b0;
        SAMPLE_VALID = 1'b0;
        idle(30);

        // Randomized mix of gaps, holds and scrambles
        for (int i = 0; i < 40; i++) begin
            int mode;
            mode = int'($urandom_range(0, 2));
            if (mode == 1) begin
                send(12'($urandom), 1'b1);
            end else begin
                send(12'($urandom), 1'b0);
                if (mode == 2) begin
                    for (int j = 0; j < 10; j++) begin
                        SAMPLE_C = 12'($urandom);
                        idle(1);
                    end
                end
                idle(int'($urandom_range(0, 30)));
            end
        end
        SAMPLE_VALID = 1'b0;

        for (int i = 0; i < 100 && exp_q.size() > 0; i++) idle(1);
        idle(5);
        check("drain", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time budget");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1);
    end

endmodule
